// File: rtl/booth_serial_adder.sv
// Multi-cycle adder for the Booth multiplier's adder-callee handshake.
// CHUNK bits are summed per clock with a registered inter-chunk carry.
module booth_serial_adder #(
  parameter int WIDTH = 9,
  parameter int CHUNK = 3
) (
  input  logic             CLK,
  input  logic             RSTK,
  input  logic [WIDTH-1:0] Adder_datain1,
  input  logic [WIDTH-1:0] Adder_datain2,
  input  logic             Adder_valid,
  output logic [WIDTH-1:0] Adder_dataout,
  output logic             Adder_carryout,
  output logic             Adder_ack,
  output logic             Adder_busy
);

  localparam int N  = WIDTH / CHUNK;
  localparam int KW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, CALC, WAIT_LOW} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             carry_q, carry_d, cout_q, cout_d;
  logic             ack_q, ack_d, busy_q, busy_d;
  logic [KW-1:0]    k_q, k_d;

  logic [CHUNK-1:0] a_sl, b_sl;
  logic [CHUNK:0]   chunk_sum;
  logic [WIDTH-1:0] sum_ins;

  // Slice select and write-back use constant indices so each chunk is a plain mux.
  always_comb begin
    a_sl = '0;
    b_sl = '0;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) begin
        a_sl = a_q[i*CHUNK +: CHUNK];
        b_sl = b_q[i*CHUNK +: CHUNK];
      end
    end
    chunk_sum = {1'b0, a_sl} + {1'b0, b_sl} + {{CHUNK{1'b0}}, carry_q};
    sum_ins   = sum_q;
    for (int i = 0; i < N; i++) begin
      if (k_q == KW'(i)) sum_ins[i*CHUNK +: CHUNK] = chunk_sum[CHUNK-1:0];
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    k_d     = k_q;
    dout_d  = dout_q;
    cout_d  = cout_q;
    ack_d   = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (Adder_valid) begin
          a_d     = Adder_datain1;
          b_d     = Adder_datain2;
          sum_d   = '0;
          carry_d = 1'b0;
          k_d     = '0;
          busy_d  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        if (!Adder_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end else begin
          sum_d   = sum_ins;
          carry_d = chunk_sum[CHUNK];
          if (k_q == KW'(N-1)) begin
            dout_d  = sum_ins;
            cout_d  = chunk_sum[CHUNK];
            ack_d   = 1'b1;
            state_d = WAIT_LOW;
          end else begin
            k_d = k_q + KW'(1);
          end
        end
      end
      WAIT_LOW: begin
        // Held request parks here so it cannot retrigger a second ack.
        if (!Adder_valid) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTK) begin
    if (!RSTK) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      k_q     <= '0;
      dout_q  <= '0;
      cout_q  <= 1'b0;
      ack_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      k_q     <= k_d;
      dout_q  <= dout_d;
      cout_q  <= cout_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
    end
  end

  assign Adder_dataout  = dout_q;
  assign Adder_carryout = cout_q;
  assign Adder_ack      = ack_q;
  assign Adder_busy     = busy_q;

endmodule

// File: tb/tb_booth_serial_adder.sv
// Randomized and directed bench for booth_serial_adder against a plain
// arithmetic reference of (A+B) with ack expected N cycles after capture.
module tb_booth_serial_adder;

  localparam int WIDTH = 9;
  localparam int CHUNK = 3;
  localparam int N     = WIDTH / CHUNK;

  logic             CLK = 1'b0;
  logic             RSTK = 1'b0;
  logic [WIDTH-1:0] din1 = '0, din2 = '0;
  logic             valid = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             cout, ack, busy;

  int nchk = 0;
  int nerr = 0;

  booth_serial_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .CLK(CLK), .RSTK(RSTK),
    .Adder_datain1(din1), .Adder_datain2(din2), .Adder_valid(valid),
    .Adder_dataout(dout), .Adder_carryout(cout),
    .Adder_ack(ack), .Adder_busy(busy)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Raise valid, wait for ack, check latency/sum; returns with ack cycle current.
  task automatic req(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    int cyc;
    int full;
    full  = int'(a) + int'(b);
    din1  = a;
    din2  = b;
    valid = 1'b1;
    step();                      // e0: capture
    chk({tag, " busy_e0"}, busy, 1);
    din1 = $urandom;             // operand changes after capture must be ignored
    din2 = $urandom;
    cyc = 0;
    do begin
      step();
      cyc++;
    end while (!ack && cyc < 20);
    chk({tag, " latency"}, cyc, N);
    chk({tag, " dout"}, dout, full % (1 << WIDTH));
    chk({tag, " cout"}, cout, full >> WIDTH);
  endtask

  // Multiplier protocol: valid held through the edge after ack, then dropped.
  task automatic op(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input string tag);
    req(a, b, tag);
    step();
    chk({tag, " ack_pulse"}, ack, 0);
    chk({tag, " busy_wait"}, busy, 1);
    valid = 1'b0;
    step();
    chk({tag, " idle"}, busy, 0);
  endtask

  initial begin
    logic [WIDTH-1:0] hold_val, ra, rb;
    int acks;

    // Reset and quiet period
    #12 RSTK = 1'b1;
    #1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("rst_quiet", {dout, cout, ack, busy}, 0);
    end

    op(9'h0FF, 9'h001, "t_0ff");
    op(9'h1FF, 9'h001, "t_1ff");
    op(9'h005, 9'h1FB, "t_sub0");
    op(9'h003, 9'h1FB, "t_subneg");

    // Held valid: one ack only, busy stays high, result stable
    req(9'h0AA, 9'h055, "t_hold");
    hold_val = dout;
    acks = 1;
    for (int i = 0; i < 8; i++) begin
      step();
      if (ack) acks++;
      chk("hold_busy", busy, 1);
      chk("hold_dout", dout, hold_val);
    end
    chk("hold_acks", acks, 1);
    valid = 1'b0;
    step();
    chk("hold_release", busy, 0);

    // Abort in CALC: valid high for e0,e1 then low
    din1 = 9'h123; din2 = 9'h0F0; valid = 1'b1;
    step();
    step();
    valid = 1'b0;
    acks = 0;
    step();
    chk("abort_busy", busy, 0);
    for (int i = 0; i < 5; i++) begin
      if (ack) acks++;
      step();
    end
    chk("abort_acks", acks, 0);
    chk("abort_dout", dout, 9'h0FF);
    chk("abort_cout", cout, 0);

    // Booth-style back-to-back stream
    for (int i = 0; i < 8; i++) begin
      ra = WIDTH'($urandom);
      rb = WIDTH'($urandom);
      op(ra, rb, $sformatf("stream%0d", i));
    end

    // Make sure dout is nonzero before the mid-op reset
    op(9'h1F0, 9'h00F, "t_pre_rst");

    // Asynchronous reset between e1 and e2
    din1 = 9'h0C3; din2 = 9'h03C; valid = 1'b1;
    step();                      // e0
    step();                      // e1
    #2 RSTK = 1'b0;
    #1;
    chk("mrst_outs", {dout, cout, ack, busy}, 0);
    #2 RSTK = 1'b1;
    valid = 1'b0;
    acks = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (ack) acks++;
    end
    chk("mrst_noack", acks, 0);
    chk("mrst_idle", busy, 0);
    op(9'h010, 9'h020, "t_post_rst");

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule

// File: doc/booth_serial_adder.md
# booth_serial_adder

Multi-cycle 9-bit adder serving the adder-callee handshake of the 8x8 Booth multiplier in the 16-bit FPU datapath. It sits directly beside the multiplier. It receives the partial-product accumulator A and either M or the two's complement of M over `Adder_datain1/2`, qualified by `Adder_valid`. It returns the sum on `Adder_dataout` and `Adder_carryout`, with a single-cycle `Adder_ack`. The block adds CHUNK bits per clock with a registered inter-chunk carry, which keeps the carry chain short for the FPU clock target.

## Interface
- WIDTH, 9, operand and result width in bits.
- CHUNK, 3, bits added per clock; WIDTH must be an integer multiple of CHUNK. N = WIDTH/CHUNK.
- CLK  input  1  single clock, rising edge.
- RSTK  input  1  reset, asynchronous and active-low.
- Adder_datain1  input  WIDTH  operand A. Sampled only on the capture edge.
- Adder_datain2  input  WIDTH  operand B. Sampled only on the capture edge.
- Adder_valid  input  1  request level from the multiplier.
- Adder_dataout  output  WIDTH  registered sum (A+B) mod 2^WIDTH.
- Adder_carryout  output  1  registered carry out of bit WIDTH-1.
- Adder_ack  output  1  registered result-valid pulse, exactly one cycle wide.
- Adder_busy  output  1  high while in CALC or WAIT_LOW.

## Operation
- States: IDLE, CALC, WAIT_LOW.
- IDLE:
  - When Adder_valid=1 at an edge, capture both operands into internal registers, clear the chunk counter and carry register, and go to CALC.
  - Adder_valid=0 keeps the block in IDLE.
- CALC, each edge:
  - Add operand slices [k*CHUNK+CHUNK-1 : k*CHUNK] plus the carry register.
  - Write the CHUNK-bit result into the sum register slice k.
  - Update the carry register and increment k.
- CALC, edge processing slice N-1:
  - Load Adder_dataout from the full sum, including slice N-1.
  - Load Adder_carryout with the final carry.
  - Set Adder_ack to 1 and go to WAIT_LOW.
- CALC abort: Adder_valid=0 at any CALC edge returns to IDLE. No ack is produced, and Adder_dataout and Adder_carryout are unchanged.
- WAIT_LOW:
  - Adder_ack is cleared on the first edge after it was set, regardless of Adder_valid.
  - Stay in WAIT_LOW while Adder_valid=1, so a held request never produces a second ack.
  - Adder_valid=0 at an edge returns to IDLE.
- Operand changes while not in IDLE are ignored.
- Adder_dataout and Adder_carryout hold their values until the next completed operation.
- Arithmetic is unsigned modulo 2^WIDTH. Signed subtraction is the caller's job: it passes ~M+1, and carryout is reported raw.
- Reset (RSTK=0, any time, including mid-CALC):
  - State goes to IDLE.
  - Adder_dataout=0, Adder_carryout=0, Adder_ack=0, Adder_busy=0.
  - Operand, sum and carry registers and the counter are cleared.
  - The interrupted operation is lost.

## Timing
- Let e0 be the edge on which Adder_valid=1 is sampled in IDLE.
  - Chunks are computed on edges e1..eN.
  - Adder_ack is high during the cycle after eN, with Adder_dataout valid in the same cycle.
  - With defaults: ack is high in the cycle after e3.
- CHUNK=WIDTH gives N=1, so ack is high in the cycle after e1.
- The ack pulse is exactly one cycle. The multiplier updates on ack=1 and drops Adder_valid at the next edge. That gives valid=1 in the first WAIT_LOW cycle and valid=0 one cycle later, so IDLE is re-entered 2 edges after ack rises.
- Fastest back-to-back sequence:
  - Valid is low for one edge and then high again.
  - The new request is captured on the first edge at which valid=1 in IDLE.
  - The next ack follows N cycles after that capture edge.
- Adder_busy is registered. It rises on e0 and falls on the edge that returns to IDLE.

## Test plan
- Reset, then no request: all outputs 0 and state IDLE for 10 cycles. Then valid=1 with 9'h0FF + 9'h001 gives ack in the cycle after e3, dataout=9'h100, carryout=0.
- Carry propagation and subtraction:
  - 9'h1FF + 9'h001 gives dataout=9'h000, carryout=1.
  - 9'h005 + 9'h1FB (A=5 minus M=5) gives 9'h000, carryout=1.
  - 9'h003 + 9'h1FB gives 9'h1FE, carryout=0.
- Held valid: keep valid=1 for 8 cycles after ack. Required: exactly one ack pulse, busy stays 1 and the dataout value is unchanged. Then drop valid, and the block is IDLE with busy=0 after that edge.
- Abort: valid=1 for 2 edges then 0 during CALC. Required: no ack, return to IDLE, dataout and carryout keep their previous values.
- Mid-operation reset: pulse RSTK low asynchronously between e1 and e2. Required: outputs go to 0 immediately, no ack, and a subsequent 9'h010 + 9'h020 gives 9'h030.
- Booth-style stream: drive 8 requests, each using the multiplier's protocol of dropping valid at the edge after ack and re-raising it one cycle later. Required: 8 acks, each exactly N cycles after its capture edge, with correct sums against a reference model.
